// File: rtl/mem_dump_tx.sv
// mem_dump_tx: walks data RAM words 0..NUM_WORDS-1 and sends each as four UART 8N1 bytes,
// most-significant byte first, on a single tx line.
module mem_dump_tx #(
  parameter int NUM_WORDS    = 64,
  parameter int ADDR_W       = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, DONE} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [31:0] word_q, word_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] cur_byte;
  logic start_q, tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic baud_end, in_frame;
  assign baud_end = baud_q == BAUD_MAX;
  assign in_frame = state_q inside {START, DATA, STOP};
  assign cur_byte = word_q[{~byte_idx_q, 3'b000} +: 8];
  assign mem_addr = word_idx_q;
  assign tx = tx_q;
  assign busy = busy_q;
  assign done = done_q;
  always_comb begin
    state_d = state_q;
    word_idx_d = word_idx_q;
    word_d = word_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d = bit_idx_q;
    shift_d = shift_q;
    baud_d = in_frame && !baud_end ? baud_q + 1'b1 : '0;
    case (state_q)
      IDLE: if (start_q) begin
        state_d = LOAD;
        word_idx_d = '0;
      end
      LOAD: begin
        word_d = mem_rdata;
        byte_idx_d = '0;
        state_d = START;
      end
      START: if (baud_end) begin
        state_d = DATA;
        shift_d = cur_byte;
        bit_idx_d = '0;
      end
      DATA: if (baud_end) begin
        shift_d = shift_q >> 1;
        bit_idx_d = bit_idx_q + 1'b1;
        state_d = bit_idx_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (baud_end) begin
        if (byte_idx_q != 2'd3) begin
          byte_idx_d = byte_idx_q + 1'b1;
          state_d = START;
        end else if (word_idx_q != LAST) begin
          word_idx_d = word_idx_q + 1'b1;
          state_d = LOAD;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        word_idx_d = '0;
      end
      default: state_d = IDLE;
    endcase
    // outputs are registered from the next state so they line up with it
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  // start is registered once before IDLE looks at it, giving LOAD one cycle after the sampling edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_idx_q <= '0;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      word_q <= '0;
      shift_q <= '0;
      start_q <= 1'b0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_idx_q <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      word_q <= word_d;
      shift_q <= shift_d;
      start_q <= start;
      tx_q <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
endmodule

// File: doc/mem_dump_tx.md
# mem_dump_tx

Debug readback unit for the single-cycle MIPS top. On a start pulse it walks the data RAM from word 0 to NUM_WORDS-1 through a combinational read port and transmits every word as four UART 8N1 bytes, most-significant byte first, on a single `tx` line. It is the hardware counterpart of the bench's memory preload: it lets a board or bench capture data-memory contents after a program has run. It sits beside `ram_data` in `top_mips`, sharing the RAM read port through a top-level mux that is outside this block.

## Interface
- NUM_WORDS, 64: number of 32-bit words dumped; must be at least 1.
- ADDR_W, 8: width of the word address; must satisfy 2^ADDR_W ≥ NUM_WORDS.
- CLKS_PER_BIT, 868: clock cycles per UART bit; must be at least 2.

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begins a dump when sampled high in IDLE; ignored otherwise.
- mem_addr  out  ADDR_W  word index presented to the RAM read port.
- mem_rdata  in  32  combinational read data for `mem_addr`.
- tx  out  1  UART serial output; idles high.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last stop bit of the last word.

## Operation
- States: IDLE, LOAD, START, DATA, STOP, DONE.
- IDLE
  - tx=1, busy=0.
  - start=1 → LOAD, with word_idx=0.
- LOAD (exactly 1 cycle)
  - Latch mem_rdata into a 32-bit word register.
  - Set byte_idx=0.
  - → START.
- START
  - Byte to send is word[31:24] when byte_idx=0, word[23:16] when byte_idx=1, and so on.
  - Load that byte into the shift register.
  - tx=0 for CLKS_PER_BIT cycles, then → DATA.
- DATA
  - 8 bits, LSB first, each held for CLKS_PER_BIT cycles.
  - A 3-bit bit counter selects the bit; → STOP after bit 7.
- STOP
  - tx=1 for CLKS_PER_BIT cycles, then:
    - byte_idx<3 → byte_idx+1, → START.
    - byte_idx=3 and word_idx<NUM_WORDS-1 → word_idx+1, → LOAD.
    - byte_idx=3 and word_idx=NUM_WORDS-1 → DONE.
- DONE (1 cycle)
  - done=1, tx=1.
  - → IDLE.
- mem_addr = word_idx at all times, zero-extended to ADDR_W.
- mem_rdata is sampled only in LOAD. Changes to RAM during a word's transmission do not affect that word.
- start asserted while busy=1 is ignored; it is not queued.
- start held high continuously re-triggers a dump on the cycle after DONE. This is legal.
- Baud counter counts 0..CLKS_PER_BIT-1. Its width is $clog2(CLKS_PER_BIT).

## Timing
- Reset (async assert, any state)
  - Outputs: tx=1, busy=0, done=0, mem_addr=0.
  - State=IDLE; all counters and registers cleared.
  - Applies immediately, including mid-bit.
  - No partial frame resumes after reset release.
- Start latency:
  - start sampled at edge k → LOAD in cycle k+1, with busy=1 from k+1.
  - START in cycle k+2, so tx falls at edge k+2.
- Frame length: exactly 10·CLKS_PER_BIT cycles; no gap between bytes of one word.
- Inter-word gap: 1 LOAD cycle with tx=1, added after the stop bit.
- Total dump, start edge to done pulse: NUM_WORDS·(1 + 40·CLKS_PER_BIT) + 1 cycles.
  - The done pulse occupies the cycle after that.
  - busy drops on the cycle after done.
- Wrap: word_idx never exceeds NUM_WORDS-1. After DONE it returns to 0 in IDLE.

## Test plan
- Basic frame
  - Stimulus: CLKS_PER_BIT=4, NUM_WORDS=1, RAM[0]=32'hA5_01_FF_00; start pulse.
  - Required: UART decoder sees bytes A5, 01, FF, 00.
  - Required: each frame is 40 cycles and there are no inter-byte gaps.
  - Required: done pulses once, 162 cycles after the start edge.
- Multi-word order
  - Stimulus: NUM_WORDS=4, RAM = 11111111, 22222222, 33333333, 44444444.
  - Required: 16 bytes in address order.
  - Required: mem_addr steps 0→3; one idle-high LOAD cycle between words.
- Start while busy
  - Stimulus: pulse start again mid-dump.
  - Required: exactly 4·NUM_WORDS bytes and a single done pulse.
- Reset mid-bit
  - Stimulus: assert rst=0 during a DATA bit that is driving 0.
  - Required: tx=1 and busy=0 immediately, before the next edge.
  - Required: a later start produces a clean dump from word 0.
- RAM change during transmission
  - Stimulus: overwrite RAM[0] while word 0 is in its second byte.
  - Required: the original word 0 bytes are sent.
- Held start
  - Stimulus: start tied high for two dumps.
  - Required: the second dump's LOAD occurs 1 cycle after the first done, and done pulses twice.
